rob_ring: RTL and testbench
===========================

# rob_ring

Parametrised in-order reorder buffer for the out-of-order core. It allocates entries at dispatch and accepts NWB result writebacks per cycle. It supplies operand values to dispatch via two tag-lookup ports and retires one entry per cycle in program order. It releases stores at head, and flushes the whole window with a redirect PC on branch mispredict or indirect jump.

## Interface
- DEPTH, 8: entry count, power of two, 4..64
- NWB, 2: writeback ports, 1..4
- XLEN, 32: data/PC width
- TAG_W, $clog2(DEPTH)+1: tag width; tag = slot index + 1, tag 0 means "no producer"
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alloc_valid/alloc_ready  in/out  1  dispatch handshake
- alloc_kind  in  2  00 ALU/LOAD, 01 BRANCH, 10 STORE, 11 JUMP
- alloc_rd  in  5  destination register (0 = none)
- alloc_pred_taken  in  1  predictor decision (BRANCH only)
- alloc_tag  out  TAG_W  tag given to the entry allocated this cycle (tail slot + 1)
- qA_tag, qB_tag  in  TAG_W  lookup tags
- qA_hit, qB_hit  out  1  producer value available
- qA_value, qB_value  out  XLEN  value if hit, else 0
- wb_valid  in  NWB  per-port valid
- wb_tag  in  NWB*TAG_W  result tags
- wb_value  in  NWB*XLEN  result value (BRANCH/JUMP: resolved target)
- wb_taken  in  NWB  actual direction (BRANCH only)
- store_req  out  1  STORE at head may write memory
- store_tag  out  TAG_W  its tag
- store_ack  in  1  memory accepted the store
- commit_valid  out  1  one-cycle retire pulse
- commit_rd  out  5  retired rd (0 if none/branch/store)
- commit_value  out  XLEN  retired value
- commit_tag  out  TAG_W  retired tag (rename table clears matching entries)
- flush  out  1  one-cycle pipeline flush
- redirect_pc  out  XLEN  fetch restart address, valid with flush

## Operation
- Per slot: busy, done, kind, rd, value, pred_taken, taken. Pointers head, tail (log2 DEPTH bits, natural wrap); count 0..DEPTH.
- Allocate when alloc_valid && alloc_ready: slot[tail] busy=1, done=0; tail++.
- alloc_ready = (count != DEPTH) && !mispredict_at_head. A commit in the same cycle does not free space for that cycle's alloc.
- Writeback: for each port with wb_valid and busy target, store value/taken and set done. Ports never carry the same tag in one cycle; a writeback to a non-busy slot is ignored.
- Lookup, combinational: hit if tag != 0, slot busy and done, or a same-cycle wb_valid matches the tag. With multiple matches the lowest port wins; a wb bypass beats stored value.
- STORE at head, not done: store_req=1, store_tag=head tag. On store_ack the slot becomes done.
- Retire, at most one per edge, when head is busy and done:
  - ALU/LOAD/STORE: commit_rd=rd (STORE gives 0), commit_value=value.
  - BRANCH: commit_rd=0; mispredict if taken != pred_taken.
  - JUMP: commit_rd=rd, commit_value=link supplied as value of wb. Always mispredict; redirect_pc = target, carried in the slot's second field.
  - Therefore JUMP writeback carries the link in wb_value and the target is latched from the wb_value of a second writeback? No: JUMP entries hold two fields. The execution unit writes the link on wb_value and the target on a dedicated port: add jump_target_in (in, XLEN), sampled with the JUMP's writeback on port 0 only.
- Mispredict retire: redirect_pc = taken ? target : fallthrough. The fallthrough is written by the branch unit in wb_value when not taken, so redirect_pc = value. Flush=1; at the same edge every slot is cleared busy=0, head=tail=0, count=0, and the alloc is blocked.
- count updates: +alloc −retire; it is unchanged when both occur.

## Timing
- Reset (rst=0 at posedge): all busy=0, head=tail=count=0. Outputs: alloc_ready=1, commit_valid=0, commit_rd=0, commit_value=0, commit_tag=0, flush=0, redirect_pc=0, store_req=0. Reset mid-stream drops all entries without a commit.
- Allocation visible for lookup from the next cycle.
- Writeback at edge N makes the slot retire-eligible at edge N+1; commit outputs are registered, so commit_valid is high in cycle N+1..N+2. Lookup hits combinationally in cycle N via bypass.
- Back-to-back retire: one per cycle while head entries are done.
- flush and commit_valid of the mispredicting branch assert in the same registered cycle; the first alloc after flush is accepted the cycle flush is high.

## Structure
- Package rob_pkg: kind encoding localparams, slot struct typedef, TAG_W function.
- One sub-module, rob_wb_match: NWB-way tag match/priority mux, used for the slot-write decode and both bypass lookups.

## Test plan
- DEPTH=8: allocate 8 ALU entries, then hold alloc_valid -> alloc_ready=0 on 9th; wb tag 1 value 0x55 -> commit_rd/value=0x55 next cycle, then alloc accepted with alloc_tag=1 (wrap).
- Out-of-order wb tags 3,2,1 on separate cycles -> commits in order tags 1,2,3, one per cycle.
- Same-cycle wb on ports 0 and 1 (tags 2, 5) plus qA_tag=5 -> qA_hit=1, qA_value=port-1 value.
- BRANCH pred_taken=0, wb_taken=1, wb_value=0x100, three younger entries -> flush=1, redirect_pc=0x100, count=0, younger entries never commit.
- STORE at head -> store_req=1 with its tag; store_ack after 3 cycles -> commit with commit_rd=0 next cycle.
- rst=0 with 5 busy entries -> all outputs at reset values, first new alloc_tag=1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: entry kinds, slot control
// record and the tag-width helper.
package rob_pkg;

  localparam logic [1:0] KIND_ALU    = 2'b00;  // ALU or LOAD
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_STORE  = 2'b10;
  localparam logic [1:0] KIND_JUMP   = 2'b11;

  localparam int unsigned RD_W = 5;

  // Per-slot control state; data fields live in separate arrays because
  // their width follows the XLEN parameter of the instantiating module.
  typedef struct packed {
    logic            busy;
    logic            done;
    logic [1:0]      kind;
    logic [RD_W-1:0] rd;
    logic            pred_taken;
    logic            taken;
  } rob_ctrl_t;

  // Tags are slot index + 1 so that tag 0 can mean "no producer".
  function automatic int unsigned tag_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_wb_match.sv
// NWB-way writeback tag matcher; the lowest-numbered matching port wins.
module rob_wb_match #(
  parameter int unsigned NWB   = 2,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic [TAG_W-1:0]     i_tag,
  input  logic [NWB-1:0]       i_wb_valid,
  input  logic [NWB*TAG_W-1:0] i_wb_tag,
  input  logic [NWB*XLEN-1:0]  i_wb_value,
  input  logic [NWB-1:0]       i_wb_taken,
  output logic                 o_hit,
  output logic [XLEN-1:0]      o_value,
  output logic                 o_taken,
  output logic                 o_port0
);

  // Priority scan from port 0 upwards; first match is kept.
  always_comb begin
    o_hit   = 1'b0;
    o_value = '0;
    o_taken = 1'b0;
    o_port0 = 1'b0;
    for (int p = 0; p < int'(NWB); p++) begin
      if (!o_hit && i_wb_valid[p] && (i_wb_tag[p*TAG_W +: TAG_W] == i_tag)) begin
        o_hit   = 1'b1;
        o_value = i_wb_value[p*XLEN +: XLEN];
        o_taken = i_wb_taken[p];
        o_port0 = (p == 0);
      end
    end
  end

endmodule

// File: rtl/rob_ring.sv
// In-order reorder buffer: dispatch allocation, multi-port writeback,
// operand lookup with writeback bypass, store release and in-order retire
// with full-window flush on mispredicted branches and jumps.
module rob_ring
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NWB   = 2,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = tag_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [1:0]           alloc_kind,
  input  logic [4:0]           alloc_rd,
  input  logic                 alloc_pred_taken,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic [TAG_W-1:0]     qA_tag,
  input  logic [TAG_W-1:0]     qB_tag,
  output logic                 qA_hit,
  output logic                 qB_hit,
  output logic [XLEN-1:0]      qA_value,
  output logic [XLEN-1:0]      qB_value,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_value,
  input  logic [NWB-1:0]       wb_taken,
  input  logic [XLEN-1:0]      jump_target_in,
  output logic                 store_req,
  output logic [TAG_W-1:0]     store_tag,
  input  logic                 store_ack,
  output logic                 commit_valid,
  output logic [4:0]           commit_rd,
  output logic [XLEN-1:0]      commit_value,
  output logic [TAG_W-1:0]     commit_tag,
  output logic                 flush,
  output logic [XLEN-1:0]      redirect_pc
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  rob_ctrl_t        r_ctrl   [DEPTH];
  logic [XLEN-1:0]  r_value  [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [TAG_W-1:0] r_count;

  logic             r_commit_valid;
  logic [4:0]       r_commit_rd;
  logic [XLEN-1:0]  r_commit_value;
  logic [TAG_W-1:0] r_commit_tag;
  logic             r_flush;
  logic [XLEN-1:0]  r_redirect_pc;

  rob_ctrl_t        w_head;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_retire;
  logic             w_mispredict;
  logic             w_alloc;
  logic             w_store_done;

  logic [DEPTH-1:0] w_slot_hit;
  logic [DEPTH-1:0] w_slot_taken;
  logic [DEPTH-1:0] w_slot_port0;
  logic [XLEN-1:0]  w_slot_value [DEPTH];

  logic             w_qa_in, w_qb_in;
  logic [IDX_W-1:0] w_qa_idx, w_qb_idx;
  logic             w_qa_byp_hit, w_qb_byp_hit;
  logic [XLEN-1:0]  w_qa_byp_value, w_qb_byp_value;
  logic             w_qa_stored, w_qb_stored;
  logic             w_unused_qa_taken, w_unused_qa_port0;
  logic             w_unused_qb_taken, w_unused_qb_port0;

  // Head decode: retire eligibility, mispredict detection, store release.
  always_comb begin
    w_head       = r_ctrl[r_head];
    w_head_tag   = TAG_W'(r_head) + TAG_W'(1);
    w_retire     = w_head.busy && w_head.done;
    w_mispredict = w_retire &&
                   ((w_head.kind == KIND_JUMP) ||
                    ((w_head.kind == KIND_BRANCH) && (w_head.taken != w_head.pred_taken)));
    alloc_ready  = (r_count != TAG_W'(DEPTH)) && !w_mispredict;
    w_alloc      = alloc_valid && alloc_ready;
    alloc_tag    = TAG_W'(r_tail) + TAG_W'(1);
    store_req    = w_head.busy && !w_head.done && (w_head.kind == KIND_STORE);
    store_tag    = w_head_tag;
    w_store_done = store_req && store_ack;
  end

  // One matcher per slot decodes which writeback port (if any) targets it.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_slot_match
    rob_wb_match #(.NWB(NWB), .TAG_W(TAG_W), .XLEN(XLEN)) u_match (
      .i_tag      (TAG_W'(i + 1)),
      .i_wb_valid (wb_valid),
      .i_wb_tag   (wb_tag),
      .i_wb_value (wb_value),
      .i_wb_taken (wb_taken),
      .o_hit      (w_slot_hit[i]),
      .o_value    (w_slot_value[i]),
      .o_taken    (w_slot_taken[i]),
      .o_port0    (w_slot_port0[i])
    );
  end

  rob_wb_match #(.NWB(NWB), .TAG_W(TAG_W), .XLEN(XLEN)) u_byp_a (
    .i_tag      (qA_tag),
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .i_wb_value (wb_value),
    .i_wb_taken (wb_taken),
    .o_hit      (w_qa_byp_hit),
    .o_value    (w_qa_byp_value),
    .o_taken    (w_unused_qa_taken),
    .o_port0    (w_unused_qa_port0)
  );

  rob_wb_match #(.NWB(NWB), .TAG_W(TAG_W), .XLEN(XLEN)) u_byp_b (
    .i_tag      (qB_tag),
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .i_wb_value (wb_value),
    .i_wb_taken (wb_taken),
    .o_hit      (w_qb_byp_hit),
    .o_value    (w_qb_byp_value),
    .o_taken    (w_unused_qb_taken),
    .o_port0    (w_unused_qb_port0)
  );

  // Operand lookup: same-cycle writeback bypass beats the stored value.
  always_comb begin
    w_qa_in     = (qA_tag != '0) && (qA_tag <= TAG_W'(DEPTH));
    w_qb_in     = (qB_tag != '0) && (qB_tag <= TAG_W'(DEPTH));
    w_qa_idx    = IDX_W'(qA_tag - TAG_W'(1));
    w_qb_idx    = IDX_W'(qB_tag - TAG_W'(1));
    w_qa_stored = w_qa_in && r_ctrl[w_qa_idx].busy && r_ctrl[w_qa_idx].done;
    w_qb_stored = w_qb_in && r_ctrl[w_qb_idx].busy && r_ctrl[w_qb_idx].done;
    qA_hit      = (w_qa_in && w_qa_byp_hit) || w_qa_stored;
    qB_hit      = (w_qb_in && w_qb_byp_hit) || w_qb_stored;
    qA_value    = '0;
    qB_value    = '0;
    if (w_qa_in && w_qa_byp_hit) qA_value = w_qa_byp_value;
    else if (w_qa_stored)        qA_value = r_value[w_qa_idx];
    if (w_qb_in && w_qb_byp_hit) qB_value = w_qb_byp_value;
    else if (w_qb_stored)        qB_value = r_value[w_qb_idx];
  end

  // Slot control: allocate at tail, complete on writeback/store ack, free at retire.
  always_ff @(posedge clk) begin
    if (!rst || w_mispredict) begin
      for (int i = 0; i < int'(DEPTH); i++) r_ctrl[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_alloc && (r_tail == IDX_W'(i))) begin
          r_ctrl[i].busy       <= 1'b1;
          r_ctrl[i].done       <= 1'b0;
          r_ctrl[i].kind       <= alloc_kind;
          r_ctrl[i].rd         <= alloc_rd;
          r_ctrl[i].pred_taken <= alloc_pred_taken;
          r_ctrl[i].taken      <= 1'b0;
        end else begin
          if (w_slot_hit[i] && r_ctrl[i].busy) begin
            r_ctrl[i].done  <= 1'b1;
            r_ctrl[i].taken <= w_slot_taken[i];
          end
          if (w_store_done && (r_head == IDX_W'(i))) r_ctrl[i].done <= 1'b1;
          if (w_retire && (r_head == IDX_W'(i)))     r_ctrl[i].busy <= 1'b0;
        end
      end
    end
  end

  // Slot data: result value, plus jump target captured with a port-0 writeback.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_alloc && (r_tail == IDX_W'(i))) begin
        r_value[i]  <= '0;
        r_target[i] <= '0;
      end else if (w_slot_hit[i] && r_ctrl[i].busy) begin
        r_value[i] <= w_slot_value[i];
        if (w_slot_port0[i] && (r_ctrl[i].kind == KIND_JUMP)) r_target[i] <= jump_target_in;
      end
    end
  end

  // Ring pointers and occupancy; a flush empties the window.
  always_ff @(posedge clk) begin
    if (!rst || w_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + IDX_W'(1);
      if (w_retire) r_head <= r_head + IDX_W'(1);
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + TAG_W'(1);
        2'b01:   r_count <= r_count - TAG_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered retire and redirect outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_commit_tag   <= '0;
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_commit_valid <= w_retire;
      r_flush        <= w_mispredict;
      if (w_retire) begin
        r_commit_rd    <= ((w_head.kind == KIND_ALU) || (w_head.kind == KIND_JUMP)) ? w_head.rd : 5'd0;
        r_commit_value <= r_value[r_head];
        r_commit_tag   <= w_head_tag;
      end
      if (w_mispredict) begin
        r_redirect_pc <= (w_head.kind == KIND_JUMP) ? r_target[r_head] : r_value[r_head];
      end
    end
  end

  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_value = r_commit_value;
  assign commit_tag   = r_commit_tag;
  assign flush        = r_flush;
  assign redirect_pc  = r_redirect_pc;

endmodule

// File: tb/tb_rob_ring.sv
// Directed bench for rob_ring with a commit scoreboard and a negedge monitor.
`timescale 1ns/1ps
module tb_rob_ring;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NWB   = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  localparam logic [1:0] K_ALU = 2'b00, K_BR = 2'b01, K_ST = 2'b10, K_JMP = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 alloc_valid = 1'b0;
  logic                 alloc_ready;
  logic [1:0]           alloc_kind = '0;
  logic [4:0]           alloc_rd = '0;
  logic                 alloc_pred_taken = 1'b0;
  logic [TAG_W-1:0]     alloc_tag;
  logic [TAG_W-1:0]     qA_tag = '0, qB_tag = '0;
  logic                 qA_hit, qB_hit;
  logic [XLEN-1:0]      qA_value, qB_value;
  logic [NWB-1:0]       wb_valid = '0;
  logic [NWB*TAG_W-1:0] wb_tag = '0;
  logic [NWB*XLEN-1:0]  wb_value = '0;
  logic [NWB-1:0]       wb_taken = '0;
  logic [XLEN-1:0]      jump_target_in = '0;
  logic                 store_req;
  logic [TAG_W-1:0]     store_tag;
  logic                 store_ack = 1'b0;
  logic                 commit_valid;
  logic [4:0]           commit_rd;
  logic [XLEN-1:0]      commit_value;
  logic [TAG_W-1:0]     commit_tag;
  logic                 flush;
  logic [XLEN-1:0]      redirect_pc;

  rob_ring #(.DEPTH(DEPTH), .NWB(NWB), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
    .alloc_rd(alloc_rd), .alloc_pred_taken(alloc_pred_taken), .alloc_tag(alloc_tag),
    .qA_tag(qA_tag), .qB_tag(qB_tag), .qA_hit(qA_hit), .qB_hit(qB_hit),
    .qA_value(qA_value), .qB_value(qB_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
    .jump_target_in(jump_target_in),
    .store_req(store_req), .store_tag(store_tag), .store_ack(store_ack),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [4:0]       rd;
    logic [XLEN-1:0]  value;
    logic             chk_value;
    logic             flush;
    logic [XLEN-1:0]  redirect;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int tag, input int rd, input logic [XLEN-1:0] value,
                          input logic chk_value, input logic fl, input logic [XLEN-1:0] redir);
    exp_t e;
    e.tag = TAG_W'(tag); e.rd = 5'(rd); e.value = value;
    e.chk_value = chk_value; e.flush = fl; e.redirect = redir;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit pulse must match the oldest expected retire.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("commit_unexpected_tag", XLEN'(commit_tag), '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("commit_tag", XLEN'(commit_tag), XLEN'(e.tag));
          check("commit_rd", XLEN'(commit_rd), XLEN'(e.rd));
          if (e.chk_value) check("commit_value", commit_value, e.value);
          check("commit_flush", XLEN'(flush), XLEN'(e.flush));
          if (e.flush) check("redirect_pc", redirect_pc, e.redirect);
        end
      end else if (flush === 1'b1) begin
        check("flush_without_commit", XLEN'(flush), '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wb();
    wb_valid = '0; wb_taken = '0; wb_tag = '0; wb_value = '0;
    jump_target_in = '0; store_ack = 1'b0;
  endtask

  task automatic set_wb(input int port, input int tag, input logic [XLEN-1:0] value, input logic taken);
    wb_valid[port] = 1'b1;
    wb_tag[port*TAG_W +: TAG_W] = TAG_W'(tag);
    wb_value[port*XLEN +: XLEN] = value;
    wb_taken[port] = taken;
  endtask

  task automatic alloc(input logic [1:0] kind, input int rd, input logic pt, input int exp_tag);
    check($sformatf("alloc_ready_t%0d", exp_tag), XLEN'(alloc_ready), 1);
    check($sformatf("alloc_tag_t%0d", exp_tag), XLEN'(alloc_tag), XLEN'(exp_tag));
    alloc_valid = 1'b1; alloc_kind = kind; alloc_rd = 5'(rd); alloc_pred_taken = pt;
    step();
    alloc_valid = 1'b0; alloc_kind = '0; alloc_rd = '0; alloc_pred_taken = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_alloc_ready"}, XLEN'(alloc_ready), 1);
    check({tagname, "_commit_valid"}, XLEN'(commit_valid), 0);
    check({tagname, "_commit_rd"}, XLEN'(commit_rd), 0);
    check({tagname, "_commit_value"}, commit_value, 0);
    check({tagname, "_commit_tag"}, XLEN'(commit_tag), 0);
    check({tagname, "_flush"}, XLEN'(flush), 0);
    check({tagname, "_redirect_pc"}, redirect_pc, 0);
    check({tagname, "_store_req"}, XLEN'(store_req), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Wait until every expected commit has been seen; returns elapsed negedges.
  task automatic wait_drain(input string name, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 50) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_timeout_left"}, XLEN'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    clr_wb();
    rst = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;

    // Fill the window, then confirm backpressure and wrap after one retire.
    for (int i = 0; i < 8; i++) alloc(K_ALU, i + 1, 1'b0, i + 1);
    alloc_valid = 1'b1;
    #1;
    check("full_alloc_ready", XLEN'(alloc_ready), 0);
    step();
    alloc_valid = 1'b0;
    push_exp(1, 1, 32'h55, 1'b1, 1'b0, '0);
    set_wb(0, 1, 32'h55, 1'b0);
    step();
    clr_wb();
    check("full_retire_cycle_alloc_ready", XLEN'(alloc_ready), 0);
    step();
    alloc(K_ALU, 9, 1'b0, 1);
    wait_drain("fill", cyc);
    do_reset();

    // Out-of-order writebacks retire in program order, one per cycle.
    push_exp(1, 10, 32'h11, 1'b1, 1'b0, '0);
    push_exp(2, 11, 32'h22, 1'b1, 1'b0, '0);
    push_exp(3, 12, 32'h33, 1'b1, 1'b0, '0);
    alloc(K_ALU, 10, 1'b0, 1);
    alloc(K_ALU, 11, 1'b0, 2);
    alloc(K_ALU, 12, 1'b0, 3);
    set_wb(0, 3, 32'h33, 1'b0); step(); clr_wb();
    set_wb(1, 2, 32'h22, 1'b0); step(); clr_wb();
    set_wb(0, 1, 32'h11, 1'b0); step(); clr_wb();
    wait_drain("ooo", cyc);
    check("ooo_drain_cycles", XLEN'(cyc), 4);
    do_reset();

    // Lookups: miss on pending, same-cycle bypass per port, stored value later.
    for (int i = 1; i <= 5; i++) begin
      push_exp(i, i, XLEN'(32'hA0 + i), 1'b1, 1'b0, '0);
      alloc(K_ALU, i, 1'b0, i);
    end
    qA_tag = 4'd3; qB_tag = 4'd0;
    #1;
    check("lookup_pending_hit", XLEN'(qA_hit), 0);
    check("lookup_pending_value", qA_value, 0);
    set_wb(0, 2, 32'hA2, 1'b0);
    set_wb(1, 5, 32'hA5, 1'b0);
    qA_tag = 4'd5; qB_tag = 4'd2;
    #1;
    check("bypass_qA_hit", XLEN'(qA_hit), 1);
    check("bypass_qA_value", qA_value, 32'hA5);
    check("bypass_qB_hit", XLEN'(qB_hit), 1);
    check("bypass_qB_value", qB_value, 32'hA2);
    step();
    clr_wb();
    qB_tag = 4'd0;
    #1;
    check("stored_qA_hit", XLEN'(qA_hit), 1);
    check("stored_qA_value", qA_value, 32'hA5);
    check("tag0_qB_hit", XLEN'(qB_hit), 0);
    qA_tag = '0;
    set_wb(0, 1, 32'hA1, 1'b0); set_wb(1, 3, 32'hA3, 1'b0); step(); clr_wb();
    set_wb(1, 4, 32'hA4, 1'b0); step(); clr_wb();
    wait_drain("lookup", cyc);
    do_reset();

    // Mispredicted branch flushes younger done entries; alloc in flush cycle.
    alloc(K_BR, 7, 1'b0, 1);
    alloc(K_ALU, 2, 1'b0, 2);
    alloc(K_ALU, 3, 1'b0, 3);
    alloc(K_ALU, 4, 1'b0, 4);
    set_wb(0, 2, 32'h2, 1'b0); set_wb(1, 3, 32'h3, 1'b0); step(); clr_wb();
    set_wb(1, 4, 32'h4, 1'b0); step(); clr_wb();
    push_exp(1, 0, 32'h100, 1'b1, 1'b1, 32'h100);
    set_wb(0, 1, 32'h100, 1'b1);
    step();
    clr_wb();
    check("mispredict_alloc_ready", XLEN'(alloc_ready), 0);
    step();
    check("flush_pulse", XLEN'(flush), 1);
    check("flush_redirect", redirect_pc, 32'h100);
    alloc(K_ALU, 5, 1'b0, 1);
    check("after_flush_pulse_clear", XLEN'(flush), 0);
    push_exp(1, 5, 32'h77, 1'b1, 1'b0, '0);
    set_wb(0, 1, 32'h77, 1'b0); step(); clr_wb();
    wait_drain("branch", cyc);
    repeat (4) step();
    do_reset();

    // Jump: commits the link, redirects to the target from port 0.
    alloc(K_JMP, 1, 1'b0, 1);
    alloc(K_ALU, 2, 1'b0, 2);
    push_exp(1, 1, 32'h44, 1'b1, 1'b1, 32'h200);
    set_wb(0, 1, 32'h44, 1'b0); jump_target_in = 32'h200;
    set_wb(1, 2, 32'h99, 1'b0);
    step();
    clr_wb();
    wait_drain("jump", cyc);
    repeat (3) step();
    do_reset();

    // Correctly predicted taken branch retires without a flush.
    alloc(K_BR, 6, 1'b1, 1);
    push_exp(1, 0, 32'h300, 1'b1, 1'b0, '0);
    set_wb(0, 1, 32'h300, 1'b1); step(); clr_wb();
    wait_drain("branch_ok", cyc);
    do_reset();

    // Store at head waits for the memory ack, then retires with rd 0.
    alloc(K_ST, 3, 1'b0, 1);
    check("store_req", XLEN'(store_req), 1);
    check("store_tag", XLEN'(store_tag), 1);
    repeat (3) step();
    check("store_req_held", XLEN'(store_req), 1);
    push_exp(1, 0, '0, 1'b0, 1'b0, '0);
    store_ack = 1'b1;
    step();
    store_ack = 1'b0;
    check("store_req_after_ack", XLEN'(store_req), 0);
    wait_drain("store", cyc);

    // Reset mid-stream drops five busy entries without committing them.
    for (int i = 1; i <= 5; i++) alloc(K_ALU, i, 1'b0, i + 1);
    set_wb(0, 4, 32'h44, 1'b0); step(); clr_wb();
    rst = 1'b0;
    step();
    check_reset_outputs("midreset");
    qA_tag = 4'd4;
    #1;
    check("midreset_lookup_hit", XLEN'(qA_hit), 0);
    qA_tag = '0;
    rst = 1'b1;
    alloc(K_ALU, 8, 1'b0, 1);
    push_exp(1, 8, 32'h88, 1'b1, 1'b0, '0);
    set_wb(0, 1, 32'h88, 1'b0); step(); clr_wb();
    wait_drain("post_reset", cyc);
    repeat (3) step();

    check("leftover_expected", XLEN'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
